// File: rtl/pipe_if_if.sv
// IF -> ID bundle: the valid/allowin handshake toward ID plus the redirect
// information ID sends back to IF.
interface pipe_if_if;
    logic        id_allowin;
    logic        id_fire;
    logic [2:0]  npc_mux_sel;
    logic [31:0] id_pc;
    logic [15:0] imm;
    logic [25:0] j_imm;
    logic [31:0] rs_in;
    logic        if_id_validto;
    logic [31:0] pc_out;
    logic [31:0] instr_out;

    // Handshake: an instruction moves IF -> ID on a rising edge where
    // if_id_validto & id_allowin; the producer holds pc_out/instr_out until then.
    modport master (
        input  id_allowin, id_fire, npc_mux_sel, id_pc, imm, j_imm, rs_in,
        output if_id_validto, pc_out, instr_out
    );
    modport slave (
        output id_allowin, id_fire, npc_mux_sel, id_pc, imm, j_imm, rs_in,
        input  if_id_validto, pc_out, instr_out
    );
endinterface

// File: rtl/pipe_if.sv
// MIPS instruction-fetch stage: owns the fetch PC, drives a 1-cycle-latency
// instruction memory and presents instructions to ID with redirect handling.
module pipe_if #(
    parameter logic [31:0] RESET_PC  = 32'h0040_0000,
    parameter logic [31:0] EX_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst,
    pipe_if_if.master   id,
    input  logic        ex,
    input  logic        eret_flush,
    input  logic [31:0] cp0_epc,
    input  logic        cp0_hlt,
    output logic        imem_en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata
);
    localparam logic [2:0] SEL_BR = 3'd1;
    localparam logic [2:0] SEL_J  = 3'd2;
    localparam logic [2:0] SEL_JR = 3'd3;

    logic [31:0] fpc_q, fpc_d;
    logic        slot_valid_q, slot_valid_d;
    logic [31:0] slot_pc_q, slot_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic        halted_q, halted_d;

    logic        adv;
    logic        br_fire;
    logic [31:0] id_pc_p4;
    logic [31:0] br_target;

    assign adv      = !halted_q && (!slot_valid_q || id.id_allowin);
    assign br_fire  = id.id_fire && (id.npc_mux_sel == SEL_BR ||
                                     id.npc_mux_sel == SEL_J  ||
                                     id.npc_mux_sel == SEL_JR);
    assign id_pc_p4 = id.id_pc + 32'd4;

    always_comb begin
        br_target = id_pc_p4;
        case (id.npc_mux_sel)
            SEL_BR:  br_target = id_pc_p4 + {{14{id.imm[15]}}, id.imm, 2'b00};
            SEL_J:   br_target = {id_pc_p4[31:28], id.j_imm, 2'b00};
            SEL_JR:  br_target = id.rs_in;
            default: br_target = id_pc_p4;
        endcase
    end

    always_comb begin
        fpc_d        = fpc_q;
        slot_valid_d = slot_valid_q;
        slot_pc_d    = slot_pc_q;
        hold_valid_d = hold_valid_q;
        hold_instr_d = hold_instr_q;
        halted_d     = halted_q;
        if (ex) begin
            fpc_d        = EX_VECTOR;
            slot_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (eret_flush) begin
            fpc_d        = cp0_epc;
            slot_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (cp0_hlt) begin
            halted_d     = 1'b1;
            slot_valid_d = 1'b0;
            hold_valid_d = 1'b0;
        end else if (adv) begin
            hold_valid_d = 1'b0;
            if (br_fire) begin
                fpc_d = br_target;
                // Slot full: it holds the delay slot, so the id_pc+8 fetch dies.
                if (slot_valid_q) begin
                    slot_valid_d = 1'b0;
                end else begin
                    slot_valid_d = 1'b1;
                    slot_pc_d    = fpc_q;
                end
            end else begin
                slot_valid_d = 1'b1;
                slot_pc_d    = fpc_q;
                fpc_d        = fpc_q + 32'd4;
            end
        end else if (slot_valid_q && !hold_valid_q) begin
            // First stall cycle: memory output is only good now, capture it.
            hold_instr_d = imem_rdata;
            hold_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fpc_q        <= RESET_PC;
            slot_valid_q <= 1'b0;
            slot_pc_q    <= 32'd0;
            hold_valid_q <= 1'b0;
            hold_instr_q <= 32'd0;
            halted_q     <= 1'b0;
        end else begin
            fpc_q        <= fpc_d;
            slot_valid_q <= slot_valid_d;
            slot_pc_q    <= slot_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_instr_q <= hold_instr_d;
            halted_q     <= halted_d;
        end
    end

    assign imem_en          = adv;
    assign imem_addr        = fpc_q;
    assign id.instr_out     = hold_valid_q ? hold_instr_q : imem_rdata;
    assign id.pc_out        = slot_pc_q;
    assign id.if_id_validto = slot_valid_q && !halted_q && !ex && !eret_flush;
endmodule

// File: tb/tb_pipe_if.sv
// Directed bench for pipe_if: sequential fetch, stall/skid, redirects,
// exception/eret flush, halt and reset recovery.
module tb_pipe_if;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ex = 1'b0;
    logic        eret_flush = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        cp0_hlt = 1'b0;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    int          checks = 0;
    int          fails = 0;

    pipe_if_if bus ();

    pipe_if #(.RESET_PC(32'h0040_0000), .EX_VECTOR(32'h0040_0004)) dut (
        .clk        (clk),
        .rst        (rst),
        .id         (bus.master),
        .ex         (ex),
        .eret_flush (eret_flush),
        .cp0_epc    (cp0_epc),
        .cp0_hlt    (cp0_hlt),
        .imem_en    (imem_en),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    // Synchronous memory; output turns to junk on non-enabled cycles.
    always @(posedge clk) imem_rdata <= imem_en ? mem_word(imem_addr) : $urandom;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic set_defaults;
        bus.id_allowin = 1'b1; bus.id_fire = 1'b0; bus.npc_mux_sel = 3'd0;
        bus.id_pc = '0; bus.imm = '0; bus.j_imm = '0; bus.rs_in = '0;
        ex = 1'b0; eret_flush = 1'b0; cp0_epc = '0; cp0_hlt = 1'b0;
    endtask

    // Leaves the bench in cycle 0: just after release, before the first live edge.
    task automatic do_reset;
        rst = 1'b0;
        set_defaults();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic test_reset;
        logic [31:0] e;
        set_defaults();
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.if_id_validto !== 1'b0) begin fails++; $display("FAIL rst_validto: got %b want 0", bus.if_id_validto); end
        checks++; if (bus.pc_out !== 32'h0) begin fails++; $display("FAIL rst_pc_out: got %h want 0", bus.pc_out); end
        checks++; if (imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL rst_addr: got %h want 00400000", imem_addr); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_en !== 1'b1) begin fails++; $display("FAIL rel_en: got %b want 1", imem_en); end
        checks++; if (bus.if_id_validto !== 1'b0) begin fails++; $display("FAIL rel_validto: got %b want 0", bus.if_id_validto); end
        for (int i = 0; i < 5; i++) begin
            cyc();
            @(negedge clk);
            e = 32'h0040_0000 + 32'(4 * i);
            checks++; if (bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL seq_validto[%0d]: got %b want 1", i, bus.if_id_validto); end
            checks++; if (bus.pc_out !== e) begin fails++; $display("FAIL seq_pc[%0d]: got %h want %h", i, bus.pc_out, e); end
            checks++; if (imem_addr !== e + 32'd4) begin fails++; $display("FAIL seq_addr[%0d]: got %h want %h", i, imem_addr, e + 32'd4); end
            checks++; if (bus.instr_out !== mem_word(e)) begin fails++; $display("FAIL seq_instr[%0d]: got %h want %h", i, bus.instr_out, mem_word(e)); end
        end
    endtask

    task automatic test_stall;
        logic [31:0] e;
        do_reset();
        repeat (3) cyc();
        bus.id_allowin = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (bus.pc_out !== 32'h0040_0008) begin fails++; $display("FAIL stall_pc[%0d]: got %h want 00400008", i, bus.pc_out); end
            checks++; if (bus.instr_out !== mem_word(32'h0040_0008)) begin fails++; $display("FAIL stall_instr[%0d]: got %h want %h", i, bus.instr_out, mem_word(32'h0040_0008)); end
            checks++; if (imem_addr !== 32'h0040_000C) begin fails++; $display("FAIL stall_fpc[%0d]: got %h want 0040000c", i, imem_addr); end
            checks++; if (imem_en !== 1'b0) begin fails++; $display("FAIL stall_en[%0d]: got %b want 0", i, imem_en); end
            cyc();
        end
        bus.id_allowin = 1'b1;
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0008) begin fails++; $display("FAIL release_pc: got %h want 00400008", bus.pc_out); end
        checks++; if (bus.instr_out !== mem_word(32'h0040_0008)) begin fails++; $display("FAIL release_instr: got %h want %h", bus.instr_out, mem_word(32'h0040_0008)); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            e = 32'h0040_000C + 32'(4 * i);
            checks++; if (bus.pc_out !== e) begin fails++; $display("FAIL after_stall_pc[%0d]: got %h want %h", i, bus.pc_out, e); end
            checks++; if (bus.instr_out !== mem_word(e)) begin fails++; $display("FAIL after_stall_instr[%0d]: got %h want %h", i, bus.instr_out, mem_word(e)); end
        end
    endtask

    // Slot holds the delay slot when the redirect fires; expect one bubble.
    task automatic test_redirect_slot_full(input logic [2:0] sel, input logic [31:0] pc,
                                           input logic [15:0] im, input logic [25:0] ji,
                                           input logic [31:0] tgt);
        do_reset();
        repeat (6) cyc();
        bus.id_fire = 1'b1; bus.npc_mux_sel = sel; bus.id_pc = pc; bus.imm = im; bus.j_imm = ji;
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0014 || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL redir%0d_dslot: got %h/%b want 00400014/1", sel, bus.pc_out, bus.if_id_validto); end
        cyc();
        bus.id_fire = 1'b0; bus.npc_mux_sel = 3'd0;
        @(negedge clk);
        checks++; if (bus.if_id_validto !== 1'b0) begin fails++; $display("FAIL redir%0d_bubble: got %b want 0", sel, bus.if_id_validto); end
        checks++; if (imem_addr !== tgt) begin fails++; $display("FAIL redir%0d_fetch: got %h want %h", sel, imem_addr, tgt); end
        cyc();
        @(negedge clk);
        checks++; if (bus.if_id_validto !== 1'b1 || bus.pc_out !== tgt) begin fails++; $display("FAIL redir%0d_target: got %h/%b want %h/1", sel, bus.pc_out, bus.if_id_validto, tgt); end
        checks++; if (bus.instr_out !== mem_word(tgt)) begin fails++; $display("FAIL redir%0d_instr: got %h want %h", sel, bus.instr_out, mem_word(tgt)); end
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== tgt + 32'd4) begin fails++; $display("FAIL redir%0d_next: got %h want %h", sel, bus.pc_out, tgt + 32'd4); end
    endtask

    task automatic test_jr_empty;
        do_reset();
        bus.id_fire = 1'b1; bus.npc_mux_sel = 3'd3; bus.id_pc = 32'h003F_FFFC; bus.rs_in = 32'h0040_0100;
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL jr_req: got %b/%h want 1/00400000", imem_en, imem_addr); end
        cyc();
        bus.id_fire = 1'b0; bus.npc_mux_sel = 3'd0;
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0000 || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL jr_dslot: got %h/%b want 00400000/1", bus.pc_out, bus.if_id_validto); end
        checks++; if (imem_addr !== 32'h0040_0100) begin fails++; $display("FAIL jr_fetch: got %h want 00400100", imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0100 || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL jr_target: got %h/%b want 00400100/1", bus.pc_out, bus.if_id_validto); end
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0104) begin fails++; $display("FAIL jr_next: got %h want 00400104", bus.pc_out); end
    endtask

    task automatic test_flush_in_stall(input bit use_eret);
        logic [31:0] tgt;
        tgt = use_eret ? 32'h0040_0020 : 32'h0040_0004;
        do_reset();
        repeat (3) cyc();
        bus.id_allowin = 1'b0; cp0_epc = 32'h0040_0020;
        cyc();
        if (use_eret) eret_flush = 1'b1; else ex = 1'b1;
        @(negedge clk);
        checks++; if (bus.if_id_validto !== 1'b0) begin fails++; $display("FAIL flush%0d_drop: got %b want 0", use_eret, bus.if_id_validto); end
        cyc();
        ex = 1'b0; eret_flush = 1'b0; bus.id_allowin = 1'b1;
        @(negedge clk);
        checks++; if (bus.if_id_validto !== 1'b0) begin fails++; $display("FAIL flush%0d_bubble: got %b want 0", use_eret, bus.if_id_validto); end
        checks++; if (imem_addr !== tgt || imem_en !== 1'b1) begin fails++; $display("FAIL flush%0d_fetch: got %h/%b want %h/1", use_eret, imem_addr, imem_en, tgt); end
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== tgt || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL flush%0d_target: got %h/%b want %h/1", use_eret, bus.pc_out, bus.if_id_validto, tgt); end
        checks++; if (bus.instr_out !== mem_word(tgt)) begin fails++; $display("FAIL flush%0d_instr: got %h want %h", use_eret, bus.instr_out, mem_word(tgt)); end
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== tgt + 32'd4) begin fails++; $display("FAIL flush%0d_next: got %h want %h", use_eret, bus.pc_out, tgt + 32'd4); end
    endtask

    task automatic test_ex_vs_branch;
        do_reset();
        repeat (2) cyc();
        ex = 1'b1; bus.id_fire = 1'b1; bus.npc_mux_sel = 3'd3; bus.rs_in = 32'h0040_0800;
        @(negedge clk);
        checks++; if (bus.if_id_validto !== 1'b0) begin fails++; $display("FAIL exbr_drop: got %b want 0", bus.if_id_validto); end
        cyc();
        ex = 1'b0; bus.id_fire = 1'b0; bus.npc_mux_sel = 3'd0;
        @(negedge clk);
        checks++; if (imem_addr !== 32'h0040_0004) begin fails++; $display("FAIL exbr_fetch: got %h want 00400004", imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0004 || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL exbr_target: got %h/%b want 00400004/1", bus.pc_out, bus.if_id_validto); end
    endtask

    task automatic test_halt;
        do_reset();
        repeat (2) cyc();
        bus.id_allowin = 1'b0; cp0_hlt = 1'b1;
        @(negedge clk);
        checks++; if (imem_en !== 1'b0 || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL halt_req_cycle: got %b/%b want 0/1", imem_en, bus.if_id_validto); end
        cyc();
        cp0_hlt = 1'b0; bus.id_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (imem_en !== 1'b0 || bus.if_id_validto !== 1'b0) begin fails++; $display("FAIL halted[%0d]: got %b/%b want 0/0", i, imem_en, bus.if_id_validto); end
            cyc();
        end
        do_reset();
        @(negedge clk);
        checks++; if (imem_en !== 1'b1 || imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL unhalt_req: got %b/%h want 1/00400000", imem_en, imem_addr); end
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0000 || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL unhalt_pc: got %h/%b want 00400000/1", bus.pc_out, bus.if_id_validto); end
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        repeat (3) cyc();
        bus.id_allowin = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (bus.if_id_validto !== 1'b0 || bus.pc_out !== 32'h0) begin fails++; $display("FAIL rms_async: got %b/%h want 0/0", bus.if_id_validto, bus.pc_out); end
        checks++; if (imem_addr !== 32'h0040_0000) begin fails++; $display("FAIL rms_addr: got %h want 00400000", imem_addr); end
        do_reset();
        cyc();
        @(negedge clk);
        checks++; if (bus.pc_out !== 32'h0040_0000 || bus.if_id_validto !== 1'b1) begin fails++; $display("FAIL rms_pc: got %h/%b want 00400000/1", bus.pc_out, bus.if_id_validto); end
        checks++; if (bus.instr_out !== mem_word(32'h0040_0000)) begin fails++; $display("FAIL rms_instr: got %h want %h", bus.instr_out, mem_word(32'h0040_0000)); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_redirect_slot_full(3'd1, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0040_0004);
        test_redirect_slot_full(3'd2, 32'h9000_0010, 16'h0, 26'h010_0050, 32'h9040_0140);
        test_jr_empty();
        test_flush_in_stall(1'b0);
        test_flush_in_stall(1'b1);
        test_ex_vs_branch();
        test_halt();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
